csi2tx_yuv4208b_p2b_pkr: RTL and testbench
==========================================

// Module: csi2tx_yuv4208b_p2b_pkr
// PURPOSE
//  Parametrised YUV420 8-bit pixel-to-byte packer for the CSI-2 TX pixel path; generational
//  successor to the fixed 32-bit YUV420-8b converter. Packs odd lines (Y only) or even lines
//  (U Y V Y) into DW_BYTES-wide words, with valid/ready backpressure on both sides. At line
//  end it flushes a byte-enabled partial word. Sits between the pixel interface and the
//  packet builder.
// PARAMETERS
//  DW_BYTES  4   output word width in bytes; legal values 4, 8
//  CNT_W     16  width of the line byte counter
// PORTS
//  clk            in   1            single clock, all logic rising-edge
//  rst_n          in   1            asynchronous active-low reset
//  conv_en        in   1            block enable; 0 = pix_rdy low, no output
//  even_line      in   1            1 = UYVY (even line), 0 = Y-only (odd line); sampled on first pixel of line
//  pixel_data     in   32           Y=[27:20], U=[17:10], V=[7:0]
//  pix_vld        in   1            pixel valid
//  pix_last       in   1            qualifies last pixel of line (with pix_vld)
//  pix_rdy        out  1            pixel accepted when pix_vld & pix_rdy
//  line_abort     in   1            synchronous clear of line state
//  dw             out  8*DW_BYTES   packed word, byte0 = first byte of stream
//  dw_be          out  DW_BYTES     byte enables (contiguous from bit0)
//  dw_vld         out  1            output valid
//  dw_last        out  1            final word of line
//  dw_rdy         in   1            downstream ready
//  line_bytes     out  CNT_W        bytes emitted in last completed line
// BEHAVIOUR
//  Reset: all outputs 0. Accumulator, fill, parity cleared. State ACTIVE.
//  Accumulator: ACC = 2*DW_BYTES bytes, plus fill count 0..ACC.
//  Byte push per accepted pixel:
//   - odd line: 1 byte (Y).
//   - even line, pixel parity 0: 3 bytes {U,Y,V} in stream order U, Y, V.
//   - even line, pixel parity 1: 1 byte (Y).
//   Parity toggles per accepted pixel and clears at line end and abort.
//  Line mode: even_line is latched on the first accepted pixel of a line. Changes of
//   even_line mid-line are ignored.
//  pix_rdy = conv_en & state==ACTIVE & fill <= ACC-3. Based on registers only; no dw_rdy
//   combinational path.
//  Output register:
//   - Loads the low DW_BYTES of the accumulator when fill >= DW_BYTES and (!dw_vld | dw_rdy).
//   - Same cycle: accumulator shifts down DW_BYTES and the pixel push appends after the
//     shifted data.
//   - Latency: the word completed by a pixel accepted at edge k shows dw_vld=1 after edge k+1.
//  Handshake: dw, dw_be, dw_last are held stable while dw_vld & !dw_rdy. dw_vld drops only
//   after the handshake when no next word is ready.
//  FSM:
//   - ACTIVE: accepting pixels. Accepting a pixel with pix_last -> FLUSH.
//   - FLUSH: pix_rdy=0. Emit full words, then the remainder rem (1..DW_BYTES-1) as a partial
//     word with dw_be=(1<<rem)-1 and unused bytes 0.
//     dw_last is set on the final word; if rem=0, the last full word carries dw_last.
//     After the dw_last handshake: line_bytes <= total emitted, parity cleared,
//     state -> ACTIVE.
//  line_bytes: internal counter adds popcount(dw_be) per handshake and saturates at
//   2^CNT_W-1. Counter clears after the line_bytes update.
//  line_abort: clears accumulator, fill, parity, counter, dw_vld; state -> ACTIVE next cycle.
//   Priority over all else except reset. line_bytes is unchanged.
//  conv_en=0 mid-line: intake stops; buffered words are still drained and FLUSH completes.
//  Reset asserted mid-line: immediate clear; no partial word is emitted.
// TESTING
//  1. DW=4, odd line, Y=0x10..0x17, 8 pixels, dw_rdy=1 -> dw=0x13121110 then 0x17161514
//     (be=F, last=1); line_bytes=8.
//  2. DW=4, even line, 4 pixels (U,Y,V)=(A0,10,B0),(--,11,--),(A2,12,B2),(--,13,--)
//     -> 0x11B010A0, 0x13B212A2 (last); line_bytes=8.
//  3. DW=4, odd line, 5 pixels 0x20..0x24 -> 0x23222120, then 0x00000024 be=0x1 last=1;
//     line_bytes=5.
//  4. DW=4, even line, 3 pixels -> 7 bytes: full word, then partial be=0x7 last=1.
//     dw_rdy held low 5 cycles: dw stable, pix_rdy drops when fill>5, no data lost.
//  5. DW=8, odd line, 12 pixels -> one full word, then a partial word be=0x0F last=1.
//  6. Mid-line line_abort after 3 pixels -> dw_vld=0, fill=0; next line of 4 Y pixels
//     emits a single clean word.
//     Repeat the same scenario with rst_n pulsed instead -> all outputs 0.

Source files
------------

// File: rtl/csi2tx_yuv4208b_p2b_pkr_if.sv
// ---------------------------------------------------------------------------
// csi2tx_yuv4208b_p2b_pkr_if
//   Pixel-in / word-out stream bundle for the YUV420 8-bit pixel-to-byte
//   packer.
//
//   Pixel side : pixel_data (Y=[27:20], U=[17:10], V=[7:0]), pix_vld,
//                pix_last, pix_rdy
//   Word side  : dw (8*DW_BYTES, byte0 = first stream byte), dw_be, dw_vld,
//                dw_last, dw_rdy
//
//   modport master : environment view (pixel source + word sink)
//   modport slave  : packer view
// ---------------------------------------------------------------------------
interface csi2tx_yuv4208b_p2b_pkr_if #(
  parameter int DW_BYTES = 4
);
  logic [31:0]           pixel_data;
  logic                  pix_vld;
  logic                  pix_last;
  logic                  pix_rdy;

  logic [8*DW_BYTES-1:0] dw;
  logic [DW_BYTES-1:0]   dw_be;
  logic                  dw_vld;
  logic                  dw_last;
  logic                  dw_rdy;

  modport master (
    output pixel_data, pix_vld, pix_last, dw_rdy,
    input  pix_rdy, dw, dw_be, dw_vld, dw_last
  );

  modport slave (
    input  pixel_data, pix_vld, pix_last, dw_rdy,
    output pix_rdy, dw, dw_be, dw_vld, dw_last
  );
endinterface

// File: rtl/csi2tx_yuv4208b_p2b_pkr.sv
// ---------------------------------------------------------------------------
// csi2tx_yuv4208b_p2b_pkr
//   YUV420 8-bit pixel-to-byte packer for the CSI-2 TX pixel path.
//   Odd lines carry Y only; even lines carry U Y V Y. Bytes are collected in
//   a 2*DW_BYTES accumulator and emitted as DW_BYTES-wide words; the tail of
//   a line goes out as a byte-enabled partial word flagged with dw_last.
//
//   Parameters : DW_BYTES (4 or 8) output word bytes, CNT_W line counter width
//   Ports      : clk, rst_n (async, active low)
//                conv_en    block enable (0 = no intake)
//                even_line  line type, latched on the first pixel of a line
//                line_abort synchronous clear of all line state
//                bus        pixel/word stream bundle (slave modport)
//                line_bytes bytes emitted in the last completed line
// ---------------------------------------------------------------------------
module csi2tx_yuv4208b_p2b_pkr #(
  parameter int DW_BYTES = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        conv_en,
  input  logic                        even_line,
  input  logic                        line_abort,
  csi2tx_yuv4208b_p2b_pkr_if.slave    bus,
  output logic [CNT_W-1:0]            line_bytes
);

  localparam int ACC    = 2 * DW_BYTES;
  localparam int WORD_W = 8 * DW_BYTES;
  localparam int ACC_W  = 8 * ACC;
  localparam int FW     = $clog2(ACC + 1);

  localparam logic [FW-1:0] FILL_DW      = FW'(DW_BYTES);
  // Worst-case push is 3 bytes, so intake stops once that would overflow.
  localparam logic [FW-1:0] FILL_RDY_MAX = FW'(ACC - 3);

  typedef enum logic {ACTIVE, FLUSH} state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [FW-1:0]       fill_q;
  logic                parity_q;
  logic                in_line_q;
  logic                mode_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [WORD_W-1:0]   dw_q;
  logic [DW_BYTES-1:0] be_q;
  logic                vld_q;
  logic                last_q;

  logic                pix_acc;
  logic                line_even;
  logic [23:0]         push_vec;
  logic [FW-1:0]       push_n;
  logic                ld;
  logic                ld_last;
  logic                hs;
  logic [FW-1:0]       pop_n;
  logic [ACC_W-1:0]    acc_sh;
  logic [ACC_W-1:0]    acc_nx;
  logic [FW-1:0]       fill_sh;
  logic [FW-1:0]       fill_nx;
  logic [DW_BYTES-1:0] be_nx;
  logic [CNT_W:0]      cnt_sum;
  logic [CNT_W-1:0]    cnt_sat;

  // Padding bits of the pixel bus carry no data.
  logic                unused_pix;
  assign unused_pix = ^{bus.pixel_data[31:28], bus.pixel_data[19:18],
                        bus.pixel_data[9:8]};

  // Depends on registers and conv_en only; dw_rdy never reaches pix_rdy.
  assign bus.pix_rdy = conv_en && (state_q == ACTIVE) && (fill_q <= FILL_RDY_MAX);
  assign pix_acc     = bus.pix_vld && bus.pix_rdy;
  assign hs          = vld_q && bus.dw_rdy;

  // The line type is taken from the port only on the first pixel of a line.
  assign line_even   = in_line_q ? mode_q : even_line;

  // A word is released when a full word is buffered, or during FLUSH for
  // whatever remains; the output register must be free or draining.
  assign ld      = (!vld_q || bus.dw_rdy) &&
                   ((fill_q >= FILL_DW) || ((state_q == FLUSH) && (fill_q != '0)));
  assign ld_last = (state_q == FLUSH) && (fill_q <= FILL_DW);
  assign pop_n   = (fill_q >= FILL_DW) ? FILL_DW : fill_q;

  // Bytes at or above fill_q are always zero, so pushes can simply be OR-ed
  // in and a partial word comes out with its unused bytes already cleared.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    push_vec = {16'h0000, bus.pixel_data[27:20]};
    push_n   = FW'(1);
    if (line_even && !parity_q) begin
      push_vec = {bus.pixel_data[7:0], bus.pixel_data[27:20], bus.pixel_data[17:10]};
      push_n   = FW'(3);
    end

    acc_sh  = ld ? (acc_q >> WORD_W) : acc_q;
    fill_sh = ld ? (fill_q - pop_n) : fill_q;
    acc_nx  = acc_sh;
    fill_nx = fill_sh;
    if (pix_acc) begin
      acc_nx  = acc_sh | (ACC_W'(push_vec) << {fill_sh, 3'b000});
      fill_nx = fill_sh + push_n;
    end

    be_nx = '0;
    for (int j = 0; j < DW_BYTES; j++) begin
      be_nx[j] = (FW'(j) < fill_q);
    end

    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'($countones(be_q));
    cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACTIVE;
      // NOTE: the accumulator is reset, not left undefined like a RAM,
      // because the zero-above-fill invariant must hold from the first line.
      acc_q      <= '0;
      fill_q     <= '0;
      parity_q   <= 1'b0;
      in_line_q  <= 1'b0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      dw_q       <= '0;
      be_q       <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      line_bytes <= '0;
    end else if (line_abort) begin
      // Drops the line in flight, including a word waiting on dw_rdy.
      state_q    <= ACTIVE;
      acc_q      <= '0;
      fill_q     <= '0;
      parity_q   <= 1'b0;
      in_line_q  <= 1'b0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      dw_q       <= '0;
      be_q       <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      acc_q  <= acc_nx;
      fill_q <= fill_nx;

      if (pix_acc) begin
        if (!in_line_q) begin
          mode_q <= even_line;
        end
        if (bus.pix_last) begin
          parity_q  <= 1'b0;
          in_line_q <= 1'b0;
          state_q   <= FLUSH;
        end else begin
          parity_q  <= ~parity_q;
          in_line_q <= 1'b1;
        end
      end

      if (ld) begin
        dw_q   <= acc_q[WORD_W-1:0];
        be_q   <= be_nx;
        last_q <= ld_last;
        vld_q  <= 1'b1;
      end else if (hs) begin
        vld_q  <= 1'b0;
      end

      // The dw_last handshake only happens in FLUSH, where no pixel is
      // accepted, so it never competes with the pixel updates above.
      if (hs) begin
        if (last_q) begin
          line_bytes <= cnt_sat;
          cnt_q      <= '0;
          parity_q   <= 1'b0;
          state_q    <= ACTIVE;
        end else begin
          cnt_q      <= cnt_sat;
        end
      end
    end
  end

  assign bus.dw      = dw_q;
  assign bus.dw_be   = be_q;
  assign bus.dw_vld  = vld_q;
  assign bus.dw_last = last_q;

endmodule

// File: tb/tb_csi2tx_yuv4208b_p2b_pkr.sv
// ---------------------------------------------------------------------------
// tb_csi2tx_yuv4208b_p2b_pkr
//   Directed bench for the YUV420 8-bit packer. A DW_BYTES=4 and a
//   DW_BYTES=8 instance share the pixel stimulus; only the instance whose
//   conv_en is high takes pixels. Expected words are queued from a byte-stream
//   model when a line is driven and compared whenever dw_vld is high.
// ---------------------------------------------------------------------------
module tb_csi2tx_yuv4208b_p2b_pkr;

  localparam int CNT_W = 16;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  be;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic conv_en4, conv_en8;
  logic even_line, line_abort;
  logic [31:0] pixel_data;
  logic pix_vld, pix_last, dw_rdy;
  logic [CNT_W-1:0] line_bytes4, line_bytes8;

  always #5 clk = ~clk;

  csi2tx_yuv4208b_p2b_pkr_if #(.DW_BYTES(4)) bus4 ();
  csi2tx_yuv4208b_p2b_pkr_if #(.DW_BYTES(8)) bus8 ();

  assign bus4.pixel_data = pixel_data;
  assign bus4.pix_vld    = pix_vld;
  assign bus4.pix_last   = pix_last;
  assign bus4.dw_rdy     = dw_rdy;
  assign bus8.pixel_data = pixel_data;
  assign bus8.pix_vld    = pix_vld;
  assign bus8.pix_last   = pix_last;
  assign bus8.dw_rdy     = dw_rdy;

  csi2tx_yuv4208b_p2b_pkr #(.DW_BYTES(4), .CNT_W(CNT_W)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .conv_en    (conv_en4),
    .even_line  (even_line),
    .line_abort (line_abort),
    .bus        (bus4),
    .line_bytes (line_bytes4)
  );

  csi2tx_yuv4208b_p2b_pkr #(.DW_BYTES(8), .CNT_W(CNT_W)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .conv_en    (conv_en8),
    .even_line  (even_line),
    .line_abort (line_abort),
    .bus        (bus8),
    .line_bytes (line_bytes8)
  );

  word_t       q4[$];
  word_t       q8[$];
  logic [31:0] px_q[$];
  int checks     = 0;
  int failures   = 0;
  int lines4     = 0;
  int lines8     = 0;
  int exp_lines4 = 0;
  int exp_lines8 = 0;
  int px_acc_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Padding bits set to 1 so a mis-sliced field shows up in the data.
  function automatic logic [31:0] mkpx(input logic [7:0] y, input logic [7:0] u,
                                       input logic [7:0] v);
    return {4'hF, y, 2'b11, u, 2'b11, v};
  endfunction

  // Output monitors: every valid word is compared to the scoreboard head,
  // which also covers stability while dw_rdy is low.
  always @(negedge clk) begin
    if (rst_n && bus4.dw_vld) begin
      if (q4.size() == 0) begin
        check("dw4_unexpected_word", {63'd0, bus4.dw_vld}, 64'd0);
      end else begin
        check("dw4_data", 64'(bus4.dw), q4[0].data);
        check("dw4_be", 64'(bus4.dw_be), 64'(q4[0].be));
        check("dw4_last", 64'(bus4.dw_last), 64'(q4[0].last));
        if (dw_rdy) begin
          if (q4[0].last) lines4++;
          void'(q4.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.dw_vld) begin
      if (q8.size() == 0) begin
        check("dw8_unexpected_word", {63'd0, bus8.dw_vld}, 64'd0);
      end else begin
        check("dw8_data", 64'(bus8.dw), q8[0].data);
        check("dw8_be", 64'(bus8.dw_be), 64'(q8[0].be));
        check("dw8_last", 64'(bus8.dw_last), 64'(q8[0].last));
        if (dw_rdy) begin
          if (q8[0].last) lines8++;
          void'(q8.pop_front());
        end
      end
    end
  end

  // Byte-stream model: builds the expected words of the line held in px_q.
  task automatic expect_line(input bit even, input int which, output int nb);
    logic [7:0] bq[$];
    word_t      w;
    for (int i = 0; i < px_q.size(); i++) begin
      if (even && (i % 2 == 0)) begin
        bq.push_back(px_q[i][17:10]);
        bq.push_back(px_q[i][27:20]);
        bq.push_back(px_q[i][7:0]);
      end else begin
        bq.push_back(px_q[i][27:20]);
      end
    end
    nb = bq.size();
    for (int s = 0; s < nb; s += which) begin
      w.data = '0;
      w.be   = '0;
      for (int b = 0; b < which; b++) begin
        if (s + b < nb) begin
          w.data[b*8 +: 8] = bq[s+b];
          w.be[b]          = 1'b1;
        end
      end
      w.last = (s + which >= nb);
      if (which == 8) q8.push_back(w);
      else            q4.push_back(w);
    end
  endtask

  // Presents px_q back to back; each pixel is bounded by a cycle budget.
  task automatic send_pixels(input bit with_last, input bit flip_mode, input int which);
    int t;
    for (int i = 0; i < px_q.size(); i++) begin
      pixel_data = px_q[i];
      pix_vld    = 1'b1;
      pix_last   = with_last && (i == px_q.size() - 1);
      t = 0;
      @(negedge clk);
      while (!((which == 8) ? bus8.pix_rdy : bus4.pix_rdy) && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        check("pix_accept_timeout", 64'(t), 64'(0));
        pix_vld  = 1'b0;
        pix_last = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      px_acc_cnt++;
      if (flip_mode && i == 0) even_line = ~even_line;
    end
    pix_vld  = 1'b0;
    pix_last = 1'b0;
  endtask

  task automatic wait_lines(input int which);
    int t;
    t = 0;
    while ((((which == 8) ? lines8 : lines4) < ((which == 8) ? exp_lines8 : exp_lines4))
           && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 1000) check("line_done_timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input bit even, input int which, input bit flip);
    int nb;
    even_line = even;
    expect_line(even, which, nb);
    send_pixels(1'b1, flip, which);
    if (which == 8) exp_lines8++;
    else            exp_lines4++;
    wait_lines(which);
    if (which == 8) check("line_bytes8", 64'(line_bytes8), 64'(nb));
    else            check("line_bytes4", 64'(line_bytes4), 64'(nb));
  endtask

  initial begin
    int nb;
    word_t w;

    rst_n      = 1'b0;
    conv_en4   = 1'b0;
    conv_en8   = 1'b0;
    even_line  = 1'b0;
    line_abort = 1'b0;
    pixel_data = '0;
    pix_vld    = 1'b0;
    pix_last   = 1'b0;
    dw_rdy     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_dw", 64'(bus4.dw), 64'd0);
    check("rst_dw_be", 64'(bus4.dw_be), 64'd0);
    check("rst_dw_vld", 64'(bus4.dw_vld), 64'd0);
    check("rst_dw_last", 64'(bus4.dw_last), 64'd0);
    check("rst_pix_rdy", 64'(bus4.pix_rdy), 64'd0);
    check("rst_line_bytes", 64'(line_bytes4), 64'd0);
    check("rst_dw8_vld", 64'(bus8.dw_vld), 64'd0);
    rst_n    = 1'b1;
    conv_en4 = 1'b1;
    @(posedge clk);
    #1;
    check("idle_pix_rdy", 64'(bus4.pix_rdy), 64'd1);

    // Odd line, 8 Y pixels: two full words, the second carries dw_last
    px_q.delete();
    for (int i = 0; i < 8; i++) px_q.push_back(mkpx(8'(16 + i), 8'h55, 8'hAA));
    run_line(1'b0, 4, 1'b0);

    // Even line UYVY: 0x11B010A0, 0x13B212A2
    px_q.delete();
    px_q.push_back(mkpx(8'h10, 8'hA0, 8'hB0));
    px_q.push_back(mkpx(8'h11, 8'hA1, 8'hB1));
    px_q.push_back(mkpx(8'h12, 8'hA2, 8'hB2));
    px_q.push_back(mkpx(8'h13, 8'hA3, 8'hB3));
    run_line(1'b1, 4, 1'b0);

    // Odd line, 5 pixels, even_line toggled after the first pixel (ignored)
    px_q.delete();
    for (int i = 0; i < 5; i++) px_q.push_back(mkpx(8'(32 + i), 8'h66, 8'h77));
    run_line(1'b0, 4, 1'b1);

    // Even line, 3 pixels (7 bytes) with dw_rdy low for 5 cycles
    px_q.delete();
    px_q.push_back(mkpx(8'h40, 8'hC0, 8'hD0));
    px_q.push_back(mkpx(8'h41, 8'hC1, 8'hD1));
    px_q.push_back(mkpx(8'h42, 8'hC2, 8'hD2));
    even_line = 1'b1;
    expect_line(1'b1, 4, nb);
    dw_rdy = 1'b0;
    send_pixels(1'b1, 1'b0, 4);
    exp_lines4++;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("flush_pix_rdy", 64'(bus4.pix_rdy), 64'd0);
    check("stall_dw_vld", 64'(bus4.dw_vld), 64'd1);
    @(posedge clk);
    #1;
    dw_rdy = 1'b1;
    wait_lines(4);
    check("line_bytes4_stall", 64'(line_bytes4), 64'(nb));

    // Odd line, 12 pixels against a stalled sink: intake stops after 10
    px_q.delete();
    for (int i = 0; i < 12; i++) px_q.push_back(mkpx(8'(80 + i), 8'h12, 8'h34));
    even_line  = 1'b0;
    expect_line(1'b0, 4, nb);
    dw_rdy     = 1'b0;
    px_acc_cnt = 0;
    fork
      send_pixels(1'b1, 1'b0, 4);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_pix_rdy", 64'(bus4.pix_rdy), 64'd0);
        check("bp_accepted", 64'(px_acc_cnt), 64'd10);
        @(posedge clk);
        #1;
        dw_rdy = 1'b1;
      end
    join
    exp_lines4++;
    wait_lines(4);
    check("line_bytes4_bp", 64'(line_bytes4), 64'(nb));

    // DW_BYTES=8, odd line of 12 pixels: full word then be=0x0F last
    conv_en4 = 1'b0;
    conv_en8 = 1'b1;
    px_q.delete();
    for (int i = 0; i < 12; i++) px_q.push_back(mkpx(8'(96 + i), 8'h21, 8'h43));
    run_line(1'b0, 8, 1'b0);
    check("line_bytes4_kept", 64'(line_bytes4), 64'd12);
    conv_en8 = 1'b0;
    conv_en4 = 1'b1;

    // Mid-line abort with a word waiting on the sink
    px_q.delete();
    px_q.push_back(mkpx(8'h30, 8'hE0, 8'hF0));
    px_q.push_back(mkpx(8'h31, 8'hE1, 8'hF1));
    px_q.push_back(mkpx(8'h32, 8'hE2, 8'hF2));
    w.data = 64'h31F030E0;
    w.be   = 8'h0F;
    w.last = 1'b0;
    q4.push_back(w);
    even_line = 1'b1;
    dw_rdy    = 1'b0;
    send_pixels(1'b0, 1'b0, 4);
    check("abort_pending_vld", 64'(bus4.dw_vld), 64'd1);
    line_abort = 1'b1;
    @(posedge clk);
    #1;
    line_abort = 1'b0;
    q4.delete();
    check("abort_dw_vld", 64'(bus4.dw_vld), 64'd0);
    check("abort_pix_rdy", 64'(bus4.pix_rdy), 64'd1);
    check("abort_line_bytes", 64'(line_bytes4), 64'd12);
    dw_rdy = 1'b1;
    px_q.delete();
    for (int i = 0; i < 4; i++) px_q.push_back(mkpx(8'(112 + i), 8'h00, 8'h00));
    run_line(1'b0, 4, 1'b0);

    // Same scenario with reset pulsed instead of line_abort
    px_q.delete();
    px_q.push_back(mkpx(8'h30, 8'hE0, 8'hF0));
    px_q.push_back(mkpx(8'h31, 8'hE1, 8'hF1));
    px_q.push_back(mkpx(8'h32, 8'hE2, 8'hF2));
    q4.push_back(w);
    even_line = 1'b1;
    dw_rdy    = 1'b0;
    send_pixels(1'b0, 1'b0, 4);
    check("rst2_pending_vld", 64'(bus4.dw_vld), 64'd1);
    conv_en4 = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst2_dw", 64'(bus4.dw), 64'd0);
    check("rst2_dw_be", 64'(bus4.dw_be), 64'd0);
    check("rst2_dw_vld", 64'(bus4.dw_vld), 64'd0);
    check("rst2_dw_last", 64'(bus4.dw_last), 64'd0);
    check("rst2_pix_rdy", 64'(bus4.pix_rdy), 64'd0);
    check("rst2_line_bytes", 64'(line_bytes4), 64'd0);
    q4.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    conv_en4 = 1'b1;
    dw_rdy   = 1'b1;
    px_q.delete();
    for (int i = 0; i < 4; i++) px_q.push_back(mkpx(8'(120 + i), 8'h00, 8'h00));
    run_line(1'b0, 4, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("end_queue4_empty", 64'(q4.size()), 64'd0);
    check("end_queue8_empty", 64'(q8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
